// File: rtl/pack_pkg.sv
// Shared definitions for the sample-byte pack link: state encodings, ring
// geometry and idle timeout, plus small arithmetic helpers.
package pack_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'h0,
    S_X1    = 4'h1,
    S_X2    = 4'h2,
    S_X3    = 4'h3,
    S_Y1    = 4'h4,
    S_Y2    = 4'h5,
    S_Y3    = 4'h6,
    S_Z1    = 4'h7,
    S_Z2    = 4'h8,
    S_Z3    = 4'h9,
    S_WRITE = 4'ha,
    S_CHECK = 4'hb,
    S_DONE  = 4'hf
  } state_e;

  localparam logic [11:0] BUF_DEPTH = 12'd4000;
  localparam logic [7:0]  TIMEOUT   = 8'd255;

  // Ring pointer step; the depth is not a power of two, so wrap explicitly.
  function automatic logic [11:0] wrap_inc(input logic [11:0] a);
    return (a == (BUF_DEPTH - 12'd1)) ? 12'd0 : (a + 12'd1);
  endfunction

  function automatic logic [31:0] sext24(input logic [23:0] v);
    return {{8{v[23]}}, v};
  endfunction

endpackage

// File: rtl/pack_gap_timer.sv
// Idle-cycle counter between bytes of one sample; saturates at TIMEOUT and
// flags the timeout while it sits there.
module pack_gap_timer
  import pack_pkg::*;
(
  input  logic clk_sys,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tmo
);

  logic [7:0] r_cnt;

  // Idle counter: clear has priority, then count until saturated.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en && (r_cnt != TIMEOUT)) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tmo = (r_cnt == TIMEOUT);

endmodule

// File: rtl/pack_store.sv
// Receive side of the sample-byte stream: rebuilds 24-bit x/y/z samples from
// bytes and writes them into the sample ring, owning the ring write pointer.
module pack_store
  import pack_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        fire_store,
  output logic        done_store,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  input  logic [11:0] len_store,
  output logic        wr_en,
  output logic [11:0] buf_waddr,
  output logic [31:0] d_x,
  output logic [31:0] d_y,
  output logic [31:0] d_z,
  output logic        err_tmo,
  output logic        err_ovf
);

  state_e          r_state;
  logic [11:0]     r_len;
  logic [11:0]     r_cnt;
  logic [11:0]     r_waddr;
  logic [8:0][7:0] r_bytes;
  logic            w_collect;
  logic            w_accept;
  logic            w_tmo;

  // X1 is excluded from the gap window: waiting for a new sample never times out.
  assign w_collect = (r_state >= S_X2) && (r_state <= S_Z3);
  assign w_accept  = rx_vld && (r_state >= S_X1) && (r_state <= S_Z3);

  pack_gap_timer u_gap_timer (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .i_clr   (w_accept || !w_collect),
    .i_en    (w_collect && !rx_vld),
    .o_tmo   (w_tmo)
  );

  assign buf_waddr = r_waddr;

  // Main FSM with byte capture, counters and all registered outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= 12'd0;
      r_cnt      <= 12'd0;
      r_waddr    <= 12'd0;
      r_bytes    <= '0;
      wr_en      <= 1'b0;
      done_store <= 1'b0;
      err_tmo    <= 1'b0;
      err_ovf    <= 1'b0;
      d_x        <= 32'd0;
      d_y        <= 32'd0;
      d_z        <= 32'd0;
    end else begin
      wr_en      <= 1'b0;
      done_store <= 1'b0;
      err_tmo    <= 1'b0;
      err_ovf    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fire_store) begin
            r_len <= len_store;
            if (len_store == 12'd0) begin
              r_state    <= S_DONE;
              done_store <= 1'b1;
            end else begin
              r_state <= S_X1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_X1, S_X2, S_X3, S_Y1, S_Y2, S_Y3, S_Z1, S_Z2, S_Z3: begin
          if (rx_vld) begin
            r_bytes[r_state - 4'd1] <= rx_data;
            if (r_state == S_Z3) begin
              r_state <= S_WRITE;
              wr_en   <= 1'b1;
              d_x     <= sext24({r_bytes[0], r_bytes[1], r_bytes[2]});
              d_y     <= sext24({r_bytes[3], r_bytes[4], r_bytes[5]});
              d_z     <= sext24({r_bytes[6], r_bytes[7], rx_data});
            end else begin
              r_state <= state_e'(r_state + 4'd1);
            end
          end else if (w_collect && w_tmo) begin
            r_bytes <= '0;
            err_tmo <= 1'b1;
            r_state <= S_X1;
          end else begin
            r_state <= r_state;
          end
        end
        S_WRITE: begin
          err_ovf <= rx_vld;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          err_ovf <= rx_vld;
          r_cnt   <= r_cnt + 12'd1;
          r_waddr <= wrap_inc(r_waddr);
          if (r_cnt == (r_len - 12'd1)) begin
            r_state    <= S_DONE;
            done_store <= 1'b1;
          end else begin
            r_state <= S_X1;
          end
        end
        S_DONE: begin
          r_cnt   <= 12'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pack_store.sv
// Directed self-checking bench for pack_store: sample reassembly, ring wrap,
// timeout, overflow, zero-length operation and mid-operation reset.
module tb_pack_store;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        fire_store;
  logic        done_store;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic [11:0] len_store;
  logic        wr_en;
  logic [11:0] buf_waddr;
  logic [31:0] d_x, d_y, d_z;
  logic        err_tmo, err_ovf;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] exp_addr = 12'd0;

  pack_store dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .fire_store (fire_store),
    .done_store (done_store),
    .rx_data    (rx_data),
    .rx_vld     (rx_vld),
    .len_store  (len_store),
    .wr_en      (wr_en),
    .buf_waddr  (buf_waddr),
    .d_x        (d_x),
    .d_y        (d_y),
    .d_z        (d_z),
    .err_tmo    (err_tmo),
    .err_ovf    (err_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [31:0] sx(input logic [23:0] v);
    return {{8{v[23]}}, v};
  endfunction

  function automatic logic [11:0] next_addr(input logic [11:0] a);
    return (a == 12'd3999) ? 12'd0 : a + 12'd1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    step();
    rx_vld  = 1'b0;
  endtask

  task automatic fire(input logic [11:0] len);
    step();
    fire_store = 1'b1;
    len_store  = len;
    step();
    fire_store = 1'b0;
  endtask

  task automatic send_sample(input logic [23:0] x, input logic [23:0] y, input logic [23:0] z,
                             input bit last, input bit inj);
    logic [71:0] s;
    s = {x, y, z};
    for (int i = 0; i < 9; i++) send_byte(s[71 - 8*i -: 8]);
    chk("wr_en_hi", {31'd0, wr_en}, 32'd1);
    chk("waddr_wr", {20'd0, buf_waddr}, {20'd0, exp_addr});
    chk("d_x", d_x, sx(x));
    chk("d_y", d_y, sx(y));
    chk("d_z", d_z, sx(z));
    if (inj) begin
      rx_data = 8'h5a;
      rx_vld  = 1'b1;
    end
    step();
    rx_vld = 1'b0;
    chk("wr_en_lo", {31'd0, wr_en}, 32'd0);
    chk("err_ovf_hit", {31'd0, err_ovf}, {31'd0, inj});
    step();
    exp_addr = next_addr(exp_addr);
    chk("done", {31'd0, done_store}, {31'd0, last});
    chk("err_ovf_clr", {31'd0, err_ovf}, 32'd0);
    chk("waddr_inc", {20'd0, buf_waddr}, {20'd0, exp_addr});
  endtask

  initial begin
    int n_tmo;
    int n_wr;
    logic [23:0] rx, ry, rz;
    rst_n = 1'b0; fire_store = 1'b0; rx_vld = 1'b0; rx_data = 8'd0; len_store = 12'd0;
    step(); step();
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_done", {31'd0, done_store}, 32'd0);
    chk("rst_waddr", {20'd0, buf_waddr}, 32'd0);
    chk("rst_dx", d_x, 32'd0);
    chk("rst_err", {30'd0, err_tmo, err_ovf}, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic: three samples, sign extension on y.
    fire(12'd3);
    send_sample(24'h123456, 24'habcdef, 24'h000001, 1'b0, 1'b0);
    send_sample(24'h123456, 24'habcdef, 24'h000001, 1'b0, 1'b0);
    send_sample(24'h123456, 24'habcdef, 24'h000001, 1'b1, 1'b0);
    chk("t1_dx", d_x, 32'h00123456);
    chk("t1_dy", d_y, 32'hffabcdef);
    chk("t1_dz", d_z, 32'h00000001);
    chk("t1_waddr", {20'd0, buf_waddr}, 32'd3);
    step();
    chk("t1_done_pulse", {31'd0, done_store}, 32'd0);

    // Overflow byte during S_WRITE, next sample unaffected.
    fire(12'd2);
    send_sample(24'h800000, 24'h7fffff, 24'h00ff00, 1'b0, 1'b1);
    send_sample(24'hfedcba, 24'h010203, 24'hc0ffee, 1'b1, 1'b0);

    // Timeout after four bytes, then a clean resend of both samples.
    fire(12'd2);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'hab);
    n_tmo = 0;
    n_wr  = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (err_tmo) n_tmo++;
      if (wr_en) n_wr++;
    end
    chk("tmo_pulses", n_tmo, 32'd1);
    chk("tmo_no_write", n_wr, 32'd0);
    chk("tmo_waddr", {20'd0, buf_waddr}, 32'd5);
    send_sample(24'h111111, 24'h222222, 24'h333333, 1'b0, 1'b0);
    send_sample(24'h444444, 24'h555555, 24'h666666, 1'b1, 1'b0);
    chk("tmo_waddr_end", {20'd0, buf_waddr}, 32'd7);

    // Advance the ring to 3998 with random data.
    fire(12'd3991);
    for (int i = 0; i < 3991; i++) begin
      rx = 24'($urandom);
      ry = 24'($urandom);
      rz = 24'($urandom);
      send_sample(rx, ry, rz, i == 3990, 1'b0);
    end
    chk("bulk_waddr", {20'd0, buf_waddr}, 32'd3998);

    // Wrap: writes at 3998, 3999, 0.
    fire(12'd3);
    send_sample(24'h0a0b0c, 24'hf0f1f2, 24'h102030, 1'b0, 1'b0);
    send_sample(24'h0a0b0d, 24'hf0f1f3, 24'h102031, 1'b0, 1'b0);
    send_sample(24'h0a0b0e, 24'hf0f1f4, 24'h102032, 1'b1, 1'b0);
    chk("wrap_waddr", {20'd0, buf_waddr}, 32'd1);

    // Zero-length operation.
    fire(12'd0);
    chk("len0_done", {31'd0, done_store}, 32'd1);
    chk("len0_wr", {31'd0, wr_en}, 32'd0);
    step();
    chk("len0_done_clr", {31'd0, done_store}, 32'd0);
    chk("len0_waddr", {20'd0, buf_waddr}, 32'd1);

    // Reset while byte 5 is on the wire.
    fire(12'd2);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    rx_data = 8'h05;
    rx_vld  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_waddr", {20'd0, buf_waddr}, 32'd0);
    chk("rst_mid_dx", d_x, 32'd0);
    chk("rst_mid_dz", d_z, 32'd0);
    chk("rst_mid_flags", {28'd0, wr_en, done_store, err_tmo, err_ovf}, 32'd0);
    rx_vld = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    fire(12'd0);
    chk("rst_idle_done", {31'd0, done_store}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
